// File: rtl/vertex_xform_sched.sv
// Schedules pose updates and vertex transforms onto one MVP engine. A vertex accepted at N starts at N+1; out_valid comes at N+4 at the earliest. Poses are always accepted.
// Backpressure: vtx_ready is low while busy or a pose is pending, and out_* hold until out_ready. Define VERTEX_XFORM_SCHED_WATCHDOG_EN to add a WAIT watchdog and err_timeout.
module vertex_xform_sched (
    input  logic        clock,
    input  logic        reset,
    input  logic        pose_valid,
    input  logic [31:0] pose_roll,
    input  logic [31:0] pose_pitch,
    input  logic [31:0] pose_yaw,
    input  logic [31:0] pose_x,
    input  logic [31:0] pose_y,
    input  logic [31:0] pose_z,
    input  logic        vtx_valid,
    output logic        vtx_ready,
    input  logic [31:0] vtx_x,
    input  logic [31:0] vtx_y,
    input  logic [31:0] vtx_z,
    input  logic [11:0] vtx_id,
    output logic        eng_start,
    output logic        eng_update,
    output logic [31:0] eng_roll,
    output logic [31:0] eng_pitch,
    output logic [31:0] eng_yaw,
    output logic [31:0] eng_x,
    output logic [31:0] eng_y,
    output logic [31:0] eng_z,
    input  logic        eng_done,
    input  logic [31:0] eng_o0,
    input  logic [31:0] eng_o1,
    input  logic [31:0] eng_o2,
    input  logic [31:0] eng_o3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_x,
    output logic [31:0] out_y,
    output logic [31:0] out_z,
    output logic [31:0] out_w,
    output logic [11:0] out_id,
    output logic        busy,
    output logic        pose_applied
`ifdef VERTEX_XFORM_SCHED_WATCHDOG_EN
    ,
    output logic        err_timeout
`endif
);

    typedef struct packed {
        logic [31:0] roll;
        logic [31:0] pitch;
        logic [31:0] yaw;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } pose_t;

    typedef enum logic [2:0] {IDLE, START, SKIP, WAIT, OUT} state_t;
    typedef enum logic {UPD, XFM} op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    pose_t       shadow_q, active_q;
    logic        pend_q, pend_d;
    logic [31:0] vx_q, vy_q, vz_q;
    logic [11:0] vid_q;
    logic [31:0] ox_q, oy_q, oz_q, ow_q;
    logic [11:0] oid_q;
    logic        grant_upd, vtx_acc, res_take;

`ifdef VERTEX_XFORM_SCHED_WATCHDOG_EN
    logic [7:0]  wd_q, wd_d;
    logic        err_q, timeout;
`endif

    // A pose offered this cycle also blocks vertices, so it is never overtaken.
    assign vtx_ready = (state_q == IDLE) && !pend_q && !pose_valid;
    assign grant_upd = (state_q == IDLE) && pend_q;
    assign vtx_acc   = vtx_valid && vtx_ready;
    assign res_take  = (state_q == WAIT) && eng_done && (op_q == XFM);

    always_comb begin
        pend_d = pend_q;
        if (grant_upd) pend_d = 1'b0;
        if (pose_valid) pend_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
`ifdef VERTEX_XFORM_SCHED_WATCHDOG_EN
        wd_d    = 8'd0;
        timeout = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    op_d    = UPD;
                    state_d = START;
                end else if (vtx_acc) begin
                    op_d    = XFM;
                    state_d = START;
                end
            end
            START: state_d = SKIP;
            SKIP: begin
                // The engine still reports done from its idle state, so done is ignored until WAIT.
                state_d = WAIT;
`ifdef VERTEX_XFORM_SCHED_WATCHDOG_EN
                wd_d    = 8'd1;
`endif
            end
            WAIT: begin
                if (eng_done) begin
                    if (op_q == UPD) state_d = IDLE;
                    else             state_d = OUT;
                end
`ifdef VERTEX_XFORM_SCHED_WATCHDOG_EN
                else if (wd_q == 8'd255) begin
                    state_d = IDLE;
                    timeout = 1'b1;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
`endif
            end
            OUT: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= UPD;
            pend_q   <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
            vx_q     <= '0;
            vy_q     <= '0;
            vz_q     <= '0;
            vid_q    <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            oz_q     <= '0;
            ow_q     <= '0;
            oid_q    <= '0;
`ifdef VERTEX_XFORM_SCHED_WATCHDOG_EN
            wd_q     <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            pend_q  <= pend_d;
            if (pose_valid)
                shadow_q <= {pose_roll, pose_pitch, pose_yaw, pose_x, pose_y, pose_z};
            if (grant_upd) active_q <= shadow_q;
            if (vtx_acc) begin
                vx_q  <= vtx_x;
                vy_q  <= vtx_y;
                vz_q  <= vtx_z;
                vid_q <= vtx_id;
            end
            if (res_take) begin
                ox_q  <= eng_o0;
                oy_q  <= eng_o1;
                oz_q  <= eng_o2;
                ow_q  <= eng_o3;
                oid_q <= vid_q;
            end
`ifdef VERTEX_XFORM_SCHED_WATCHDOG_EN
            wd_q <= wd_d;
            if (timeout) err_q <= 1'b1;
`endif
        end
    end

    assign eng_start    = (state_q == START);
    assign eng_update   = (state_q == START) && (op_q == UPD);
    assign eng_roll     = active_q.roll;
    assign eng_pitch    = active_q.pitch;
    assign eng_yaw      = active_q.yaw;
    assign eng_x        = (op_q == UPD) ? active_q.x : vx_q;
    assign eng_y        = (op_q == UPD) ? active_q.y : vy_q;
    assign eng_z        = (op_q == UPD) ? active_q.z : vz_q;
    assign out_valid    = (state_q == OUT);
    assign out_x        = ox_q;
    assign out_y        = oy_q;
    assign out_z        = oz_q;
    assign out_w        = ow_q;
    assign out_id       = oid_q;
    assign busy         = (state_q != IDLE);
    assign pose_applied = !reset && (state_q == WAIT) && eng_done && (op_q == UPD);
`ifdef VERTEX_XFORM_SCHED_WATCHDOG_EN
    assign err_timeout  = err_q;
`endif

endmodule

// File: tb/tb_vertex_xform_sched.sv
// Randomised and directed bench for vertex_xform_sched with an engine model and a queue-based reference.
module tb_vertex_xform_sched;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pose_valid = 1'b0;
    logic [31:0] pose_roll = '0, pose_pitch = '0, pose_yaw = '0, pose_x = '0, pose_y = '0, pose_z = '0;
    logic        vtx_valid = 1'b0;
    logic        vtx_ready;
    logic [31:0] vtx_x = '0, vtx_y = '0, vtx_z = '0;
    logic [11:0] vtx_id = '0;
    logic        eng_start, eng_update;
    logic [31:0] eng_roll, eng_pitch, eng_yaw, eng_x, eng_y, eng_z;
    logic        eng_done;
    logic [31:0] eng_o0 = '0, eng_o1 = '0, eng_o2 = '0, eng_o3 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_x, out_y, out_z, out_w;
    logic [11:0] out_id;
    logic        busy, pose_applied;
`ifdef VERTEX_XFORM_SCHED_WATCHDOG_EN
    logic        err_timeout;
`endif

    always #5 clock = ~clock;

    vertex_xform_sched dut (
        .clock(clock), .reset(reset),
        .pose_valid(pose_valid), .pose_roll(pose_roll), .pose_pitch(pose_pitch), .pose_yaw(pose_yaw),
        .pose_x(pose_x), .pose_y(pose_y), .pose_z(pose_z),
        .vtx_valid(vtx_valid), .vtx_ready(vtx_ready), .vtx_x(vtx_x), .vtx_y(vtx_y), .vtx_z(vtx_z), .vtx_id(vtx_id),
        .eng_start(eng_start), .eng_update(eng_update), .eng_roll(eng_roll), .eng_pitch(eng_pitch),
        .eng_yaw(eng_yaw), .eng_x(eng_x), .eng_y(eng_y), .eng_z(eng_z),
        .eng_done(eng_done), .eng_o0(eng_o0), .eng_o1(eng_o1), .eng_o2(eng_o2), .eng_o3(eng_o3),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_z(out_z),
        .out_w(out_w), .out_id(out_id), .busy(busy), .pose_applied(pose_applied)
`ifdef VERTEX_XFORM_SCHED_WATCHDOG_EN
        , .err_timeout(err_timeout)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Engine model: done is high while idle, low while computing; results appear only when done.
    int           eng_cnt  = 0;
    int           eng_lat  = 3;
    bit           eng_hang = 1'b0;
    logic [127:0] res_next = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    logic [127:0] res_pend = '0;

    assign eng_done = (eng_cnt == 0);

    always @(posedge clock) begin
        if (reset) begin
            eng_cnt <= 0;
        end else if (eng_start) begin
            res_pend <= res_next;
            res_next <= {$urandom, $urandom, $urandom, $urandom};
            eng_cnt  <= eng_hang ? 1000000 : eng_lat;
            if (!eng_hang && eng_lat == 0) {eng_o0, eng_o1, eng_o2, eng_o3} <= res_next;
            else {eng_o0, eng_o1, eng_o2, eng_o3} <= {$urandom, $urandom, $urandom, $urandom};
        end else if (eng_cnt > 1) begin
            eng_cnt <= eng_cnt - 1;
            {eng_o0, eng_o1, eng_o2, eng_o3} <= {$urandom, $urandom, $urandom, $urandom};
        end else if (eng_cnt == 1) begin
            eng_cnt <= 0;
            {eng_o0, eng_o1, eng_o2, eng_o3} <= res_pend;
        end
    end

    // Reference model: last-written pose, accepted vertices, expected results in order.
    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [11:0] id;
    } vtx_t;

    vtx_t         vq[$];
    logic [11:0]  idq[$];
    logic [127:0] resq[$];
    logic [191:0] shadow_m = '0, prev_shadow = '0, last_upd_pose = '0;
    int           n_starts = 0, n_upd_start = 0, n_applied = 0, n_out = 0;
    bit           prev_start = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            vq.delete();
            idq.delete();
            resq.delete();
            shadow_m    = '0;
            prev_shadow = '0;
            prev_start  = 1'b0;
        end else begin
            if (eng_start) begin
                n_starts++;
                chk("start_single_cycle", prev_start, 1'b0);
                if (eng_update) begin
                    n_upd_start++;
                    last_upd_pose = {eng_roll, eng_pitch, eng_yaw, eng_x, eng_y, eng_z};
                    chk("upd_pose", last_upd_pose, prev_shadow);
                end else begin
                    chk("xfm_has_vertex", vq.size() > 0, 1'b1);
                    chk("xfm_rpy", {eng_roll, eng_pitch, eng_yaw}, prev_shadow[191:96]);
                    if (vq.size() > 0) begin
                        vtx_t v;
                        v = vq.pop_front();
                        chk("xfm_xyz", {eng_x, eng_y, eng_z}, {v.x, v.y, v.z});
                        idq.push_back(v.id);
                        resq.push_back(res_next);
                    end
                end
            end else begin
                chk("update_outside_start", eng_update, 1'b0);
            end
            prev_start = eng_start;
            if (vtx_valid && vtx_ready) begin
                chk("accept_idle", busy, 1'b0);
                chk("accept_pose_applied", {eng_roll, eng_pitch, eng_yaw}, shadow_m[191:96]);
                vq.push_back({vtx_x, vtx_y, vtx_z, vtx_id});
            end
            if (pose_applied) begin
                n_applied++;
                chk("applied_has_update", n_applied <= n_upd_start, 1'b1);
            end
            if (out_valid) begin
                chk("out_expected", resq.size() > 0 && idq.size() > 0, 1'b1);
                if (resq.size() > 0 && idq.size() > 0) begin
                    chk("out_data", {out_x, out_y, out_z, out_w, out_id}, {resq[0], idq[0]});
                    if (out_ready) begin
                        void'(resq.pop_front());
                        void'(idq.pop_front());
                        n_out++;
                    end
                end
            end
            prev_shadow = shadow_m;
            if (pose_valid) shadow_m = {pose_roll, pose_pitch, pose_yaw, pose_x, pose_y, pose_z};
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic sig_sel(input int s);
        case (s)
            0:       return eng_start;
            1:       return pose_applied;
            default: return out_valid;
        endcase
    endfunction

    task automatic wait_for(input int s, input int max, output int n);
        n = 0;
        while (!sig_sel(s) && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic set_pose(input logic [191:0] p);
        {pose_roll, pose_pitch, pose_yaw, pose_x, pose_y, pose_z} = p;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pose_valid = 1'b0;
        vtx_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: run still going at %0t, limit 500000", $time);
        $fatal(1);
    end

    initial begin
        int n, s0, u0, a0, cnt;
        logic [191:0] p2;
        bit acc_prev;

        // Reset state
        do_reset();
        chk("rst_vtx_ready", vtx_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_outputs", {out_valid, eng_start, eng_update, pose_applied}, 4'b0);
        chk("rst_pose", {eng_roll, eng_pitch, eng_yaw, eng_x, eng_y, eng_z}, 192'b0);
        chk("rst_out_data", {out_x, out_y, out_z, out_w, out_id}, 140'b0);

        // Pose update with a 50-cycle engine
        eng_lat = 50;
        set_pose({32'h0, 32'h0, 32'h0, 32'h3f800000, 32'h40000000, 32'h40400000});
        pose_valid = 1'b1;
        u0 = n_upd_start;
        tick();
        pose_valid = 1'b0;
        wait_for(0, 10, n);
        chk("upd_start_seen", n < 10, 1'b1);
        chk("upd_eng_update", eng_update, 1'b1);
        chk("upd_eng_xyz", {eng_x, eng_y, eng_z}, {32'h3f800000, 32'h40000000, 32'h40400000});
        wait_for(1, 100, n);
        chk("upd_applied_seen", n < 100, 1'b1);
        tick();
        chk("upd_applied_pulse", pose_applied, 1'b0);
        chk("upd_idle_after", {busy, vtx_ready}, 2'b01);
        chk("upd_one_start", n_upd_start - u0, 1);

        // Vertex transform latency with a 10-cycle engine
        eng_lat = 10;
        vtx_valid = 1'b1;
        {vtx_x, vtx_y, vtx_z, vtx_id} = {32'h3f800000, 32'h0, 32'h0, 12'd5};
        #1;
        chk("xfm_ready", vtx_ready, 1'b1);
        tick();
        vtx_valid = 1'b0;
        chk("xfm_start_next", {eng_start, eng_update}, 2'b10);
        chk("xfm_eng_x", eng_x, 32'h3f800000);
        wait_for(2, 40, n);
        chk("xfm_latency", 1 + n, 13);
        chk("xfm_out", {out_x, out_y, out_z, out_w, out_id}, {res_pend, 12'd5});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("xfm_idle_after", busy, 1'b0);

        // Pose and vertex in the same cycle: update first
        eng_lat = 3;
        set_pose({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        pose_valid = 1'b1;
        vtx_valid = 1'b1;
        {vtx_x, vtx_y, vtx_z, vtx_id} = {$urandom, $urandom, $urandom, 12'h03c};
        #1;
        chk("pv_same_cycle_ready", vtx_ready, 1'b0);
        tick();
        pose_valid = 1'b0;
        #1;
        chk("pv_pending_ready", vtx_ready, 1'b0);
        wait_for(0, 10, n);
        chk("pv_update_first", {eng_start, eng_update}, 2'b11);
        wait_for(1, 50, n);
        chk("pv_applied_seen", n < 50, 1'b1);
        chk("pv_ready_in_apply", vtx_ready, 1'b0);
        tick();
        chk("pv_ready_after", vtx_ready, 1'b1);
        tick();
        vtx_valid = 1'b0;
        chk("pv_vertex_started", {eng_start, eng_update}, 2'b10);
        out_ready = 1'b1;
        wait_for(2, 30, n);
        chk("pv_out_seen", n < 30, 1'b1);
        tick();
        out_ready = 1'b0;

        // Two poses during a transform collapse into one update with the later pose
        eng_lat = 20;
        vtx_valid = 1'b1;
        {vtx_x, vtx_y, vtx_z, vtx_id} = {$urandom, $urandom, $urandom, 12'h123};
        tick();
        vtx_valid = 1'b0;
        wait_for(0, 5, n);
        repeat (3) tick();
        set_pose({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        pose_valid = 1'b1;
        tick();
        pose_valid = 1'b0;
        repeat (2) tick();
        p2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        set_pose(p2);
        pose_valid = 1'b1;
        tick();
        pose_valid = 1'b0;
        wait_for(2, 40, n);
        chk("pp_out_seen", n < 40, 1'b1);
        s0 = n_starts;
        u0 = n_upd_start;
        a0 = n_applied;
        eng_lat = 4;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (40) tick();
        chk("pp_one_start", n_starts - s0, 1);
        chk("pp_one_update", n_upd_start - u0, 1);
        chk("pp_one_applied", n_applied - a0, 1);
        chk("pp_second_pose", last_upd_pose, p2);

        // Output held under backpressure
        eng_lat = 2;
        vtx_valid = 1'b1;
        {vtx_x, vtx_y, vtx_z, vtx_id} = {$urandom, $urandom, $urandom, 12'h7a1};
        tick();
        {vtx_x, vtx_y, vtx_z, vtx_id} = {$urandom, $urandom, $urandom, 12'h7a2};
        wait_for(2, 20, n);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_data", {out_x, out_y, out_z, out_w, out_id}, {res_pend, 12'h7a1});
            chk("bp_no_ready", vtx_ready, 1'b0);
        end
        out_ready = 1'b1;
        vtx_valid = 1'b0;
        tick();
        out_ready = 1'b0;

        // Reset in the tenth WAIT cycle abandons the transform
        eng_hang = 1'b1;
        vtx_valid = 1'b1;
        {vtx_x, vtx_y, vtx_z, vtx_id} = {$urandom, $urandom, $urandom, 12'h0ee};
        tick();
        vtx_valid = 1'b0;
        chk("rw_started", eng_start, 1'b1);
        repeat (11) tick();
        reset = 1'b1;
        chk("rw_busy_before", busy, 1'b1);
        tick();
        reset = 1'b0;
        eng_hang = 1'b0;
        chk("rw_after", {busy, out_valid, eng_start, vtx_ready}, 4'b0001);
        cnt = 0;
        repeat (10) begin
            tick();
            if (out_valid) cnt++;
        end
        chk("rw_no_output", cnt, 0);

`ifdef VERTEX_XFORM_SCHED_WATCHDOG_EN
        // Engine never finishes: watchdog fires after 255 WAIT cycles
        eng_hang = 1'b1;
        vtx_valid = 1'b1;
        {vtx_x, vtx_y, vtx_z, vtx_id} = {$urandom, $urandom, $urandom, 12'h0dd};
        tick();
        vtx_valid = 1'b0;
        chk("wd_started", eng_start, 1'b1);
        repeat (256) tick();
        chk("wd_before", {err_timeout, busy}, 2'b01);
        tick();
        chk("wd_fired", {err_timeout, busy}, 2'b10);
        repeat (5) tick();
        chk("wd_sticky", err_timeout, 1'b1);
        eng_hang = 1'b0;
        do_reset();
        chk("wd_cleared", err_timeout, 1'b0);
`endif

        // Random traffic against the reference model
        acc_prev = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            pose_valid = ($urandom_range(0, 19) == 0);
            if (pose_valid) set_pose({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            if (!vtx_valid || acc_prev) begin
                vtx_valid = ($urandom_range(0, 2) != 0);
                {vtx_x, vtx_y, vtx_z} = {$urandom, $urandom, $urandom};
                vtx_id = 12'($urandom);
            end
            out_ready = $urandom_range(0, 1);
            eng_lat = $urandom_range(0, 8);
            #1;
            acc_prev = vtx_valid && vtx_ready;
        end
        tick();
        pose_valid = 1'b0;
        vtx_valid = 1'b0;
        out_ready = 1'b1;
        repeat (100) tick();
        chk("drain_idle", busy, 1'b0);
        chk("drain_vertices", vq.size() + idq.size() + resq.size(), 0);
        chk("drain_updates", n_upd_start, n_applied);
        chk("drain_outputs_seen", n_out > 50, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vertex_xform_sched.md
VERTEX_XFORM_SCHED -- requirements
Module: vertex_xform_sched

Interface
REQ-001 SHALL have port clock  input  1  rising-edge clock; all state changes on this edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports pose_valid  input  1, and pose_roll, pose_pitch, pose_yaw, pose_x, pose_y, pose_z  input  32 each: new IEEE-754 pose offered; always accepted, no ready.
REQ-004 SHALL have ports vtx_valid  input  1, vtx_ready  output  1, vtx_x, vtx_y, vtx_z  input  32 each, vtx_id  input  12: vertex request handshake.
REQ-005 SHALL have ports eng_start  output  1, eng_update  output  1, eng_roll, eng_pitch, eng_yaw, eng_x, eng_y, eng_z  output  32 each: drive the MVP engine.
REQ-006 SHALL have ports eng_done  input  1, eng_o0, eng_o1, eng_o2, eng_o3  input  32 each: engine done and engine result column 0.
REQ-007 SHALL have ports out_valid  input/output per handshake (out_valid  output  1, out_ready  input  1), out_x, out_y, out_z, out_w  output  32 each, out_id  output  12: transformed vertex.
REQ-008 SHALL have ports busy  output  1 (state not IDLE) and pose_applied  output  1 (one-cycle pulse when an update completes).

Function
REQ-009 SHALL implement states IDLE, START, SKIP, WAIT, OUT, with a 1-bit op register: UPD or XFM.
REQ-010 SHALL register pose_valid data into a shadow pose and set pose_pending; last write wins; a set in the same cycle as a clear wins.
REQ-011 SHALL, in IDLE, grant in priority order: pose_pending -> op=UPD; else vtx_valid -> op=XFM; else remain IDLE.
REQ-012 SHALL assert vtx_ready only in IDLE with pose_pending low; a vertex is accepted on vtx_valid&vtx_ready and its x/y/z/id are latched.
REQ-013 SHALL, on an UPD grant, copy the shadow pose to the active pose and clear pose_pending in the same cycle.
REQ-014 SHALL hold eng_roll/pitch/yaw at the active pose at all times.
REQ-015 SHALL mux eng_x/y/z: active pose translation while op=UPD; latched vertex while op=XFM; both held stable from START until leaving WAIT.
REQ-016 SHALL assert eng_start for exactly one cycle in START, with eng_update = (op==UPD); eng_update SHALL be 0 outside START.
REQ-017 SHALL ignore eng_done in START and SKIP (the engine reports done while idle); SKIP SHALL last exactly one cycle.
REQ-018 SHALL, in WAIT on eng_done=1, go to IDLE and pulse pose_applied when op=UPD, or go to OUT and latch eng_o0..3 into out_x/y/z/w plus out_id when op=XFM.
REQ-019 SHALL hold out_valid high in OUT with stable data until out_ready; on out_ready go to IDLE.
REQ-020 SHALL give a minimum vertex latency of 4 cycles plus engine time: accept at N, start at N+1, earliest out_valid at N+4.
REQ-021 SHALL let a pose arriving mid-operation not disturb the current operation; it is serviced at the next IDLE, ahead of waiting vertices.

Reset
REQ-022 SHALL, on reset, go to IDLE and zero pose_pending, active and shadow pose, eng_start, eng_update, out_valid, out_* data, pose_applied, busy and the watchdog; reset mid-operation SHALL abandon the operation without output.
REQ-023 SHALL assert vtx_ready in the first cycle after reset release.

Configuration
REQ-024 SHALL, with macro VERTEX_XFORM_SCHED_WATCHDOG_EN defined: count cycles in WAIT with an 8-bit counter; at count 255 without eng_done, go to IDLE, discard the operation and set sticky output err_timeout (1 bit), cleared only by reset.
REQ-025 SHALL, without VERTEX_XFORM_SCHED_WATCHDOG_EN: have no counter, no err_timeout port, and wait in WAIT indefinitely.

Verification
REQ-026 Pose (0,0,0,1.0,2.0,3.0) pulsed, engine model done after 50 cycles -> one eng_start with eng_update=1, eng_x=32'h3f800000, then pose_applied pulse.
REQ-027 Vertex (1.0,0,0,id=5) with engine model returning o0..3=(A,B,C,D) after 10 cycles -> eng_update=0, out_valid at accept+13, out_id=5, outputs A,B,C,D.
REQ-028 Pose and vertex offered in the same IDLE cycle -> vtx_ready=0; update first; vertex accepted in the IDLE cycle after pose_applied.
REQ-029 Two poses during an XFM -> after out handshake, a single update using the second pose.
REQ-030 out_ready held low 20 cycles -> out_valid and data stable, vtx_ready=0 throughout; reset in cycle 10 of WAIT -> IDLE next cycle, out_valid=0.
REQ-031 (WATCHDOG_EN) eng_done never returns -> err_timeout=1 after 255 WAIT cycles, busy=0 next cycle.
